axil_arbiter_wr: RTL and testbench
==================================

Name: axil_arbiter_wr

Overview:
Round-robin write-channel arbiter for the AXI-Lite interconnect, sharing the write path between NUMBER_MASTER masters.
- Owns the grant for a complete write transaction: request (AW+W valid) through B-channel handshake.
- The granted index drives the interconnect's write muxes, which feed the write address decoder.
- Exactly one master owns the write path at a time; ownership is released only on the B handshake.

Parameters:
- NUMBER_MASTER, 4: number of requesting masters; must be >= 2.
- IDX_WIDTH, $clog2(NUMBER_MASTER): width of the grant index.
- TIMEOUT_CYCLES, 1024: BUSY-state watchdog limit; used only with the optional feature.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; synchronous, active-low.
- m_axil_awvalid  in  NUMBER_MASTER  per-master AW valid.
- m_axil_wvalid  in  NUMBER_MASTER  per-master W valid.
- m_axil_bready  in  NUMBER_MASTER  per-master B ready.
- s_axil_bvalid  in  1  B valid returned from the slave side (decoded path).
- grant  out  NUMBER_MASTER  one-hot grant, registered.
- grant_idx  out  IDX_WIDTH  binary index of the granted master, registered.
- grant_valid  out  1  high while any grant is held.
- timeout_err  out  1  one-cycle pulse on watchdog release.

Behaviour:
- Reset, all synchronous on aresetn=0:
  - state=IDLE; grant=0; grant_idx=0; grant_valid=0; timeout_err=0.
  - Priority pointer ptr=0, so master 0 has highest priority after reset.
- Request of master i: req[i] = m_axil_awvalid[i] && m_axil_wvalid[i]. AW-only or W-only requests are ignored.
- State IDLE:
  - If req != 0: select the first requester searching i = ptr, ptr+1, ..., wrapping modulo NUMBER_MASTER.
  - Register grant, grant_idx and grant_valid=1 at the next edge; state goes to BUSY.
  - Grant latency: 1 cycle from request to grant.
  - If req == 0: stay in IDLE; outputs unchanged (0).
- State BUSY:
  - Grant is held, independent of the granted master's valids. A master dropping valid does not release the grant.
  - Release condition: s_axil_bvalid && m_axil_bready[grant_idx].
  - On release, at the next edge: grant=0, grant_valid=0, state=IDLE, ptr=(grant_idx+1) mod NUMBER_MASTER.
  - grant_idx keeps its last value while idle.
- Arbitration cadence: at least one IDLE cycle between consecutive grants. The earliest re-grant is 2 cycles after the B handshake cycle.
- Simultaneous events: a new request arriving in the release cycle is evaluated in the following IDLE cycle, using the updated ptr.
- Ignored inputs:
  - m_axil_bready of non-granted masters is ignored.
  - s_axil_bvalid while in IDLE is ignored.
- Fairness: rotating pointer. With all NUMBER_MASTER requesting continuously, each master is granted once per NUMBER_MASTER transactions.
- Reset mid-BUSY: the grant drops at the reset edge and ptr returns to 0. No B handshake is required.
- Invariant: grant is 0 or one-hot, and grant_valid == |grant.

Optional Feature:
- Macro: AXIL_ARB_WR_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES-1 without a release, the arbiter forces the release exactly as a normal B handshake would: grant=0, state=IDLE, ptr advances.
  - timeout_err=1 for that one cycle.
  - A normal release in the same cycle takes precedence; no error is flagged.
- Disabled: no counter is built; timeout_err is tied 0; the grant is held indefinitely until the B handshake.

Test Plan:
- Reset then idle: aresetn=0 for 3 cycles, then all requests 0 for 10 cycles -> grant=0, grant_valid=0, timeout_err=0 throughout.
- Single requester:
  - Master 2 raises awvalid+wvalid -> next cycle grant=4'b0100, grant_idx=2.
  - bvalid=1 with bready[2]=1 for one cycle -> grant=0 on the following edge.
- Round robin: masters 0–3 request continuously, each B handshake completed 3 cycles after grant -> grant_idx sequence 0,1,2,3,0.
- Half request and hold:
  - Master 1 with awvalid=1, wvalid=0 -> no grant.
  - Master 1 asserts both -> granted; then drops both valids while bvalid=0 -> grant stays 4'b0010 until bvalid && bready[1].
- Reset mid-transaction: assert aresetn=0 while master 3 is granted -> grant=0 at the reset edge; afterwards masters 1 and 3 request -> master 1 granted (ptr=0).
- Timeout (macro on, TIMEOUT_CYCLES=8): master 0 granted, bvalid held 0 -> release after 8 BUSY cycles, timeout_err pulses once, next grant goes to master 1 if requesting.

Source files
------------

// File: rtl/axil_arbiter_wr.sv
// Round-robin write-channel arbiter: one master owns the AXI-Lite write path from AW+W request to B handshake.
// Optional BUSY watchdog enabled by defining AXIL_ARB_WR_TIMEOUT_EN.
module axil_arbiter_wr #(
   parameter int NUMBER_MASTER  = 4,
   parameter int IDX_WIDTH      = $clog2(NUMBER_MASTER),
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [NUMBER_MASTER-1:0] m_axil_awvalid,
   input  logic [NUMBER_MASTER-1:0] m_axil_wvalid,
   input  logic [NUMBER_MASTER-1:0] m_axil_bready,
   input  logic                     s_axil_bvalid,
   output logic [NUMBER_MASTER-1:0] grant,
   output logic [IDX_WIDTH-1:0]     grant_idx,
   output logic                     grant_valid,
   output logic                     timeout_err
);

   typedef enum logic {IDLE, BUSY} state_t;

   if (NUMBER_MASTER < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_param
      $error("axil_arbiter_wr: NUMBER_MASTER and TIMEOUT_CYCLES must be >= 2");
   end

   state_t                   state_q;
   logic [NUMBER_MASTER-1:0] grant_q;
   logic [IDX_WIDTH-1:0]     grant_idx_q;
   logic                     grant_valid_q;
   logic [IDX_WIDTH-1:0]     ptr_q;

   logic [NUMBER_MASTER-1:0] req;
   logic [IDX_WIDTH-1:0]     sel_idx;
   logic                     sel_found;
   logic [IDX_WIDTH-1:0]     ptr_d;
   logic                     b_release;

   assign req       = m_axil_awvalid & m_axil_wvalid;
   assign b_release = s_axil_bvalid && m_axil_bready[grant_idx_q];
   assign ptr_d     = (int'(grant_idx_q) == NUMBER_MASTER - 1) ? '0 : grant_idx_q + 1'b1;

   // Search starts at ptr and wraps, so the first hit is the round-robin winner.
   always_comb begin
      int idx;
      idx       = 0;
      sel_idx   = '0;
      sel_found = 1'b0;
      for (int k = 0; k < NUMBER_MASTER; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUMBER_MASTER) idx = idx - NUMBER_MASTER;
         if (!sel_found && req[idx]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_WIDTH'(idx);
         end
      end
   end

`ifdef AXIL_ARB_WR_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q;
   logic             timeout_err_q;
   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         grant_idx_q   <= '0;
         grant_valid_q <= 1'b0;
         ptr_q         <= '0;
`ifdef AXIL_ARB_WR_TIMEOUT_EN
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
`ifdef AXIL_ARB_WR_TIMEOUT_EN
         timeout_err_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (sel_found) begin
                  state_q       <= BUSY;
                  grant_q       <= NUMBER_MASTER'(1) << sel_idx;
                  grant_idx_q   <= sel_idx;
                  grant_valid_q <= 1'b1;
`ifdef AXIL_ARB_WR_TIMEOUT_EN
                  cnt_q         <= '0;
`endif
               end
            end
            BUSY: begin
               if (b_release) begin
                  state_q       <= IDLE;
                  grant_q       <= '0;
                  grant_valid_q <= 1'b0;
                  ptr_q         <= ptr_d;
`ifdef AXIL_ARB_WR_TIMEOUT_EN
               end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  // Forced release behaves like a B handshake, plus the error pulse.
                  state_q       <= IDLE;
                  grant_q       <= '0;
                  grant_valid_q <= 1'b0;
                  ptr_q         <= ptr_d;
                  timeout_err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
`endif
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign grant       = grant_q;
   assign grant_idx   = grant_idx_q;
   assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_axil_arbiter_wr.sv
// Directed bench for axil_arbiter_wr (4 masters, watchdog limit 8 when AXIL_ARB_WR_TIMEOUT_EN is defined).
module tb_axil_arbiter_wr;

   logic       aclk = 1'b0;
   logic       aresetn;
   logic [3:0] m_axil_awvalid;
   logic [3:0] m_axil_wvalid;
   logic [3:0] m_axil_bready;
   logic       s_axil_bvalid;
   logic [3:0] grant;
   logic [1:0] grant_idx;
   logic       grant_valid;
   logic       timeout_err;

   int checks   = 0;
   int failures = 0;

   axil_arbiter_wr #(
      .NUMBER_MASTER (4),
      .IDX_WIDTH     (2),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .m_axil_awvalid(m_axil_awvalid),
      .m_axil_wvalid (m_axil_wvalid),
      .m_axil_bready (m_axil_bready),
      .s_axil_bvalid (s_axil_bvalid),
      .grant         (grant),
      .grant_idx     (grant_idx),
      .grant_valid   (grant_valid),
      .timeout_err   (timeout_err)
   );

   always #5 aclk = ~aclk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic set_req(input logic [3:0] aw, input logic [3:0] w);
      m_axil_awvalid = aw;
      m_axil_wvalid  = w;
   endtask

   task automatic handshake(input logic [3:0] br);
      s_axil_bvalid = 1'b1;
      m_axil_bready = br;
      tick();
      s_axil_bvalid = 1'b0;
      m_axil_bready = 4'b0000;
   endtask

   initial begin
      int rr_exp[5] = '{0, 1, 2, 3, 0};

      aresetn = 1'b0;
      set_req(4'b0000, 4'b0000);
      m_axil_bready = 4'b0000;
      s_axil_bvalid = 1'b0;
      repeat (3) tick();
      check_eq("rst_grant", 32'(grant), 32'h0);
      check_eq("rst_idx", 32'(grant_idx), 32'h0);
      check_eq("rst_valid", 32'(grant_valid), 32'h0);
      check_eq("rst_terr", 32'(timeout_err), 32'h0);

      aresetn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == 4) s_axil_bvalid = 1'b1;  // B valid while idle must be ignored
         tick();
         check_eq($sformatf("idle_grant_%0d", i), {27'h0, timeout_err, grant}, 32'h0);
      end
      s_axil_bvalid = 1'b0;

      // Single requester, master 2
      set_req(4'b0100, 4'b0100);
      tick();
      check_eq("single_grant", 32'(grant), 32'h4);
      check_eq("single_idx", 32'(grant_idx), 32'h2);
      check_eq("single_valid", 32'(grant_valid), 32'h1);
      set_req(4'b0000, 4'b0000);
      handshake(4'b1011);  // bready of non-granted masters only
      check_eq("other_bready_ignored", 32'(grant), 32'h4);
      handshake(4'b0100);
      check_eq("single_release", 32'(grant), 32'h0);
      check_eq("single_release_valid", 32'(grant_valid), 32'h0);
      check_eq("idx_kept_idle", 32'(grant_idx), 32'h2);

      // Round robin from ptr=0
      aresetn = 1'b0;
      tick();
      aresetn = 1'b1;
      set_req(4'b1111, 4'b1111);
      for (int t = 0; t < 5; t++) begin
         tick();
         check_eq($sformatf("rr_idx_%0d", t), 32'(grant_idx), 32'(rr_exp[t]));
         check_eq($sformatf("rr_grant_%0d", t), 32'(grant), 32'(4'b0001 << rr_exp[t]));
         tick();
         tick();
         handshake(4'b1111);
         check_eq($sformatf("rr_gap_%0d", t), 32'(grant_valid), 32'h0);
      end
      set_req(4'b0000, 4'b0000);

      // Half request then hold after valids drop (ptr is now 1)
      set_req(4'b0010, 4'b0000);
      tick();
      tick();
      check_eq("half_req_no_grant", 32'(grant), 32'h0);
      set_req(4'b0010, 4'b0010);
      tick();
      check_eq("full_req_grant", 32'(grant), 32'h2);
      set_req(4'b0000, 4'b0000);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq($sformatf("hold_%0d", i), 32'(grant), 32'h2);
      end
      handshake(4'b0010);
      check_eq("hold_release", 32'(grant), 32'h0);

      // Reset while master 3 holds the grant
      set_req(4'b1000, 4'b1000);
      tick();
      check_eq("m3_grant", 32'(grant), 32'h8);
      set_req(4'b0000, 4'b0000);
      aresetn = 1'b0;
      tick();
      check_eq("midrst_grant", 32'(grant), 32'h0);
      check_eq("midrst_valid", 32'(grant_valid), 32'h0);
      aresetn = 1'b1;
      set_req(4'b1010, 4'b1010);
      tick();
      check_eq("post_rst_grant", 32'(grant), 32'h2);
      check_eq("post_rst_idx", 32'(grant_idx), 32'h1);
      set_req(4'b0000, 4'b0000);
      handshake(4'b0010);
      check_eq("post_rst_release", 32'(grant), 32'h0);

      // Long hold without B: watchdog on forces release, off holds forever
      aresetn = 1'b0;
      tick();
      aresetn = 1'b1;
      set_req(4'b0011, 4'b0011);
      tick();
      check_eq("wd_grant", 32'(grant), 32'h1);
`ifdef AXIL_ARB_WR_TIMEOUT_EN
      repeat (7) tick();
      check_eq("wd_before", {27'h0, timeout_err, grant}, 32'h1);
      tick();
      check_eq("wd_release", 32'(grant), 32'h0);
      check_eq("wd_terr", 32'(timeout_err), 32'h1);
      tick();
      check_eq("wd_terr_pulse", 32'(timeout_err), 32'h0);
      check_eq("wd_next_grant", 32'(grant), 32'h2);
      set_req(4'b0000, 4'b0000);
      handshake(4'b0010);
      check_eq("wd_next_release", 32'(grant), 32'h0);
`else
      repeat (20) tick();
      check_eq("nowd_hold", {27'h0, timeout_err, grant}, 32'h1);
      set_req(4'b0000, 4'b0000);
      handshake(4'b0001);
      check_eq("nowd_release", 32'(grant), 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
